vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA pixel/line counters with registered sync/blank, start pulses,
// frame counter and a reset-black delay pipeline for sync/blank.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  if (SYNC_DELAY < 0 || SYNC_DELAY > 4 || H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_params
    $error("vga_timing_gen: SYNC_DELAY must be 0..4 and H/V totals at most 1023");
  end

  logic       h_wrap, v_wrap;
  logic [9:0] nx, ny;

  always_comb begin
    h_wrap = DrawX == H_LAST;
    v_wrap = DrawY == V_LAST;
    nx     = h_wrap ? 10'd0 : DrawX + 10'd1;
    ny     = h_wrap ? (v_wrap ? 10'd0 : DrawY + 10'd1) : DrawY;
  end

  // sync/blank are decoded from the next counter values so they register alongside them
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= nx;
      DrawY       <= ny;
      hs          <= !(nx >= HS_BEG && nx < HS_END);
      vs          <= !(ny >= VS_BEG && ny < VS_END);
      blank       <= nx < H_VIS && ny < V_VIS;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) frame_count <= frame_count + 8'd1;
    end
  end

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign hs_d    = hs;
    assign vs_d    = vs;
    assign blank_d = blank;
  end else begin : g_delay
    logic [SYNC_DELAY-1:0] hs_p, vs_p, bl_p;
    // reset fills every stage with inactive sync and blanking so the display stays black
    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_p <= '1;
        vs_p <= '1;
        bl_p <= '0;
      end else begin
        hs_p <= (hs_p << 1) | SYNC_DELAY'(hs);
        vs_p <= (vs_p << 1) | SYNC_DELAY'(vs);
        bl_p <= (bl_p << 1) | SYNC_DELAY'(blank);
      end
    end
    assign hs_d    = hs_p[SYNC_DELAY-1];
    assign vs_d    = vs_p[SYNC_DELAY-1];
    assign blank_d = bl_p[SYNC_DELAY-1];
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default-timing instance (2-cycle delay) plus a tiny-timing instance
// (no delay) checked every cycle against an arithmetic model of elapsed cycles.
module tb_vga_timing_gen;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [9:0] DrawX, DrawY, DrawX_b, DrawY_b;
  logic hs, vs, blank, hs_d, vs_d, blank_d, line_start, frame_start;
  logic hs_b, vs_b, blank_b, hs_d_b, vs_d_b, blank_d_b, line_start_b, frame_start_b;
  logic [7:0] frame_count, frame_count_b;

  vga_timing_gen #(.SYNC_DELAY(2)) dut_a (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .hs(hs), .vs(vs), .blank(blank), .hs_d(hs_d), .vs_d(vs_d), .blank_d(blank_d),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count));

  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(0)) dut_b (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX_b), .DrawY(DrawY_b),
    .hs(hs_b), .vs(vs_b), .blank(blank_b), .hs_d(hs_d_b), .vs_d(vs_d_b), .blank_d(blank_d_b),
    .line_start(line_start_b), .frame_start(frame_start_b), .frame_count(frame_count_b));

  typedef struct packed {
    logic [9:0] x, y;
    logic hs, vs, blank, ls, fs;
    logic [7:0] fc;
  } exp_t;

  int checks = 0, errors = 0;
  int t = 0;

  // t = rising edges seen since the last reset release
  always @(posedge vga_clk or negedge reset_n)
    if (!reset_n) t <= 0; else t <= t + 1;

  function automatic exp_t model(int n, int hv, int hf, int hsn, int hb, int vv, int vf, int vsn, int vb);
    exp_t m;
    int ht = hv + hf + hsn + hb;
    int vt = vv + vf + vsn + vb;
    int x = n % ht;
    int y = (n / ht) % vt;
    m.x = 10'(x);
    m.y = 10'(y);
    m.hs = !(x >= hv + hf && x < hv + hf + hsn);
    m.vs = !(y >= vv + vf && y < vv + vf + vsn);
    m.blank = x < hv && y < vv;
    m.ls = n > 0 && x == 0;
    m.fs = n > 0 && x == 0 && y == 0;
    m.fc = 8'((n / (ht * vt)) % 256);
    return m;
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", n, t, act, exp);
    end
  endtask

  always @(negedge vga_clk) begin
    exp_t a, ad, b;
    a = model(t, 640, 16, 96, 48, 480, 10, 2, 33);
    b = model(t, 8, 2, 3, 2, 6, 1, 2, 2);
    if (t < 2) begin
      ad = '0;
      ad.hs = 1'b1;
      ad.vs = 1'b1;
    end else ad = model(t - 2, 640, 16, 96, 48, 480, 10, 2, 33);
    chk("a_x", DrawX, a.x);            chk("a_y", DrawY, a.y);
    chk("a_hs", hs, a.hs);             chk("a_vs", vs, a.vs);
    chk("a_blank", blank, a.blank);    chk("a_line_start", line_start, a.ls);
    chk("a_frame_start", frame_start, a.fs); chk("a_frame_count", frame_count, a.fc);
    chk("a_hs_d", hs_d, ad.hs);        chk("a_vs_d", vs_d, ad.vs);
    chk("a_blank_d", blank_d, ad.blank);
    chk("b_x", DrawX_b, b.x);          chk("b_y", DrawY_b, b.y);
    chk("b_hs", hs_b, b.hs);           chk("b_vs", vs_b, b.vs);
    chk("b_blank", blank_b, b.blank);  chk("b_line_start", line_start_b, b.ls);
    chk("b_frame_start", frame_start_b, b.fs); chk("b_frame_count", frame_count_b, b.fc);
    chk("b_hs_d", hs_d_b, b.hs);       chk("b_vs_d", vs_d_b, b.vs);
    chk("b_blank_d", blank_d_b, b.blank);
  end

  int hs_low, ls_cnt, ls_x, ls_y, found;
  int vs_low_b, blank_hi_b, hs_low_b, fs_cnt_b;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    chk("rst_x", DrawX, 0);        chk("rst_hs", hs, 1);
    chk("rst_blank", blank, 1);    chk("rst_hs_d", hs_d, 1);
    chk("rst_blank_d", blank_d, 0); chk("rst_frame_count", frame_count, 0);
    reset_n = 1'b1;
    hs_low = 0; ls_cnt = 0; ls_x = -1; ls_y = -1;
    for (int i = 0; i < 800; i++) begin
      @(negedge vga_clk);
      if (!hs) hs_low++;
      if (line_start) begin ls_cnt++; ls_x = DrawX; ls_y = DrawY; end
    end
    chk("line_hs_low_cycles", hs_low, 96);
    chk("line_start_count", ls_cnt, 1);
    chk("line_start_x", ls_x, 0);
    chk("line_start_y", ls_y, 1);
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge vga_clk);
      if (DrawX == 300 && DrawY == 1) found = 1;
    end
    chk("reach_x300", found, 1);
    @(posedge vga_clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_x", DrawX, 0);         chk("async_y", DrawY, 0);
    chk("async_blank_d", blank_d, 0); chk("async_frame_count_b", frame_count_b, 0);
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    vs_low_b = 0; blank_hi_b = 0; hs_low_b = 0; fs_cnt_b = 0;
    for (int i = 0; i < 165; i++) begin
      @(negedge vga_clk);
      if (i == 0) begin
        chk("restart_x", DrawX, 1);   chk("restart_y", DrawY, 0);
        chk("restart_frame_start", frame_start, 0);
        chk("restart_line_start", line_start, 0);
      end
      if (!vs_b) vs_low_b++;
      if (!hs_b) hs_low_b++;
      if (blank_b) blank_hi_b++;
      if (frame_start_b) fs_cnt_b++;
    end
    chk("frame_vs_low_cycles", vs_low_b, 30);
    chk("frame_hs_low_cycles", hs_low_b, 33);
    chk("frame_blank_cycles", blank_hi_b, 48);
    chk("frame_start_count", fs_cnt_b, 1);
    chk("frame_count_one", frame_count_b, 1);
    repeat (256 * 165 - 1 - 165) @(negedge vga_clk);
    chk("fc_before_wrap", frame_count_b, 255);
    chk("fs_before_wrap", frame_start_b, 0);
    @(negedge vga_clk);
    chk("fs_at_wrap", frame_start_b, 1);
    chk("fc_wrapped", frame_count_b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
